// File: rtl/search_arb.sv
// Round-robin arbiter sharing one rule-search engine between requesters.
// One search in flight at a time; all outputs registered, with a response timeout.
module search_arb #(
    parameter int unsigned C_NUM_REQ        = 4,
    parameter int unsigned C_NUM_TABLE      = 4,
    parameter int unsigned C_RULE_WIDTH     = 24,
    parameter int unsigned C_MEM_DATA_WIDTH = 56,
    parameter int unsigned C_MEM_ADDR_WIDTH = 8,
    parameter int unsigned C_TIMEOUT        = 64
) (
    input  logic                                     clk_i,
    input  logic                                     rstn_i,
    input  logic [C_NUM_REQ-1:0]                     req_i,
    input  logic [C_NUM_REQ*C_RULE_WIDTH-1:0]        req_key_i,
    output logic [C_NUM_REQ-1:0]                     gnt_o,
    output logic [C_NUM_REQ-1:0]                     rsp_vd_o,
    output logic                                     rsp_hit_o,
    output logic                                     rsp_tout_o,
    output logic [3:0]                               rsp_tab_o,
    output logic [C_MEM_ADDR_WIDTH-1:0]              rsp_addr_o,
    output logic [C_MEM_DATA_WIDTH-C_RULE_WIDTH-1:0] rsp_data_o,
    output logic                                     search_o,
    output logic [C_RULE_WIDTH-1:0]                  key_o,
    input  logic [C_NUM_TABLE-1:0]                   busy_i,
    input  logic                                     hit_vd_i,
    input  logic                                     hit_i,
    input  logic [3:0]                               hit_tab_i,
    input  logic [C_MEM_ADDR_WIDTH-1:0]              hit_addr_i,
    input  logic [C_MEM_DATA_WIDTH-C_RULE_WIDTH-1:0] hit_data_i,
    output logic                                     err_stray_o
);
    localparam int unsigned DW = C_MEM_DATA_WIDTH - C_RULE_WIDTH;
    localparam int unsigned PW = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;
    localparam int unsigned CW = $clog2(C_TIMEOUT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                r_state, w_state_nxt;
    logic [PW-1:0]         r_ptr, w_ptr_nxt;
    logic [PW-1:0]         r_owner, w_owner_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [C_NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic [C_NUM_REQ-1:0]  r_rsp_vd, w_rsp_vd_nxt;
    logic                  r_search, w_search_nxt;
    logic                  r_hit, w_hit_nxt;
    logic                  r_tout, w_tout_nxt;
    logic                  r_stray, w_stray_nxt;
    logic [3:0]            r_tab, w_tab_nxt;
    logic [C_MEM_ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [DW-1:0]         r_data, w_data_nxt;
    logic [C_RULE_WIDTH-1:0] r_key, w_key_nxt;

    logic                  w_found;
    logic [PW-1:0]         w_win;
    logic [PW-1:0]         w_scan;
    logic [PW-1:0]         w_ptr_adv;
    logic [C_NUM_REQ-1:0]  w_owner_oh;

    // Walk the request vector starting at the pointer, wrapping at C_NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_scan  = r_ptr;
        for (int unsigned i = 0; i < C_NUM_REQ; i++) begin
            if (!w_found && req_i[w_scan]) begin
                w_found = 1'b1;
                w_win   = w_scan;
            end
            w_scan = (w_scan == PW'(C_NUM_REQ - 1)) ? '0 : w_scan + PW'(1);
        end
    end

    always_comb begin
        w_owner_oh          = '0;
        w_owner_oh[r_owner] = 1'b1;
        w_ptr_adv = (r_owner == PW'(C_NUM_REQ - 1)) ? '0 : r_owner + PW'(1);
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_owner_nxt  = r_owner;
        w_cnt_nxt    = r_cnt;
        w_gnt_nxt    = '0;
        w_rsp_vd_nxt = '0;
        w_search_nxt = 1'b0;
        w_stray_nxt  = 1'b0;
        w_hit_nxt    = r_hit;
        w_tout_nxt   = r_tout;
        w_tab_nxt    = r_tab;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        w_key_nxt    = r_key;
        case (r_state)
            S_IDLE: begin
                w_stray_nxt = hit_vd_i;
                // The cycle a response is presented is not a sample cycle.
                if (w_found && busy_i == '0 && r_rsp_vd == '0) begin
                    w_gnt_nxt        = '0;
                    w_gnt_nxt[w_win] = 1'b1;
                    w_search_nxt     = 1'b1;
                    w_key_nxt        = req_key_i[w_win*C_RULE_WIDTH +: C_RULE_WIDTH];
                    w_owner_nxt      = w_win;
                    w_cnt_nxt        = '0;
                    w_state_nxt      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (hit_vd_i) begin
                    w_rsp_vd_nxt = w_owner_oh;
                    w_hit_nxt    = hit_i;
                    w_tout_nxt   = 1'b0;
                    w_tab_nxt    = hit_tab_i;
                    w_addr_nxt   = hit_addr_i;
                    w_data_nxt   = hit_data_i;
                    w_ptr_nxt    = w_ptr_adv;
                    w_state_nxt  = S_IDLE;
                end else if (r_cnt == CW'(C_TIMEOUT - 1)) begin
                    w_rsp_vd_nxt = w_owner_oh;
                    w_hit_nxt    = 1'b0;
                    w_tout_nxt   = 1'b1;
                    w_tab_nxt    = '0;
                    w_addr_nxt   = '0;
                    w_data_nxt   = '0;
                    w_ptr_nxt    = w_ptr_adv;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_rsp_vd <= '0;
            r_search <= 1'b0;
            r_stray  <= 1'b0;
            r_hit    <= 1'b0;
            r_tout   <= 1'b0;
            r_tab    <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_key    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_owner  <= w_owner_nxt;
            r_cnt    <= w_cnt_nxt;
            r_gnt    <= w_gnt_nxt;
            r_rsp_vd <= w_rsp_vd_nxt;
            r_search <= w_search_nxt;
            r_stray  <= w_stray_nxt;
            r_hit    <= w_hit_nxt;
            r_tout   <= w_tout_nxt;
            r_tab    <= w_tab_nxt;
            r_addr   <= w_addr_nxt;
            r_data   <= w_data_nxt;
            r_key    <= w_key_nxt;
        end
    end

    assign gnt_o       = r_gnt;
    assign rsp_vd_o    = r_rsp_vd;
    assign rsp_hit_o   = r_hit;
    assign rsp_tout_o  = r_tout;
    assign rsp_tab_o   = r_tab;
    assign rsp_addr_o  = r_addr;
    assign rsp_data_o  = r_data;
    assign search_o    = r_search;
    assign key_o       = r_key;
    assign err_stray_o = r_stray;

endmodule

// File: tb/tb_search_arb.sv
// Bench for search_arb: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_search_arb;
    localparam int N   = 4;
    localparam int NT  = 4;
    localparam int RW  = 24;
    localparam int MDW = 56;
    localparam int AW  = 8;
    localparam int T   = 64;
    localparam int DW  = MDW - RW;

    logic            clk_i  = 1'b0;
    logic            rstn_i = 1'b1;
    logic [N-1:0]    req_i  = '0;
    logic [N*RW-1:0] req_key_i = '0;
    logic [N-1:0]    gnt_o, rsp_vd_o;
    logic            rsp_hit_o, rsp_tout_o, search_o, err_stray_o;
    logic [3:0]      rsp_tab_o;
    logic [AW-1:0]   rsp_addr_o;
    logic [DW-1:0]   rsp_data_o;
    logic [RW-1:0]   key_o;
    logic [NT-1:0]   busy_i = '0;
    logic            hit_vd_i = 1'b0, hit_i = 1'b0;
    logic [3:0]      hit_tab_i = '0;
    logic [AW-1:0]   hit_addr_i = '0;
    logic [DW-1:0]   hit_data_i = '0;

    search_arb #(
        .C_NUM_REQ(N), .C_NUM_TABLE(NT), .C_RULE_WIDTH(RW),
        .C_MEM_DATA_WIDTH(MDW), .C_MEM_ADDR_WIDTH(AW), .C_TIMEOUT(T)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .req_key_i(req_key_i),
        .gnt_o(gnt_o), .rsp_vd_o(rsp_vd_o), .rsp_hit_o(rsp_hit_o),
        .rsp_tout_o(rsp_tout_o), .rsp_tab_o(rsp_tab_o), .rsp_addr_o(rsp_addr_o),
        .rsp_data_o(rsp_data_o), .search_o(search_o), .key_o(key_o),
        .busy_i(busy_i), .hit_vd_i(hit_vd_i), .hit_i(hit_i), .hit_tab_i(hit_tab_i),
        .hit_addr_i(hit_addr_i), .hit_data_i(hit_data_i), .err_stray_o(err_stray_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit            m_out   = 1'b0;
    int            m_age   = 0;
    int            m_owner = 0;
    int            m_ptr   = 0;
    bit            m_prev_rsp;
    int            m_w;
    logic [N-1:0]  exp_gnt = '0, exp_rsp_vd = '0;
    logic          exp_search = 1'b0, exp_stray = 1'b0, exp_hit = 1'b0, exp_tout = 1'b0;
    logic [3:0]    exp_tab = '0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_data = '0;
    logic [RW-1:0] exp_key = '0;

    function automatic int pick(input int r, input int p);
        for (int i = 0; i < N; i++)
            if (((r >> ((p + i) % N)) & 1) != 0) return (p + i) % N;
        return -1;
    endfunction

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            m_out = 1'b0; m_age = 0; m_owner = 0; m_ptr = 0;
            exp_gnt = '0; exp_rsp_vd = '0; exp_search = 1'b0; exp_stray = 1'b0;
            exp_hit = 1'b0; exp_tout = 1'b0; exp_tab = '0; exp_addr = '0;
            exp_data = '0; exp_key = '0;
        end else begin
            m_prev_rsp = (exp_rsp_vd != '0);
            exp_gnt = '0; exp_rsp_vd = '0; exp_search = 1'b0; exp_stray = 1'b0;
            if (!m_out) begin
                exp_stray = hit_vd_i;
                if (!m_prev_rsp && req_i != '0 && busy_i == '0) begin
                    m_w        = pick(int'(req_i), m_ptr);
                    exp_gnt    = N'(1) << m_w;
                    exp_search = 1'b1;
                    exp_key    = req_key_i[m_w*RW +: RW];
                    m_owner    = m_w;
                    m_out      = 1'b1;
                    m_age      = 0;
                end
            end else if (hit_vd_i) begin
                exp_rsp_vd = N'(1) << m_owner;
                exp_hit = hit_i; exp_tout = 1'b0; exp_tab = hit_tab_i;
                exp_addr = hit_addr_i; exp_data = hit_data_i;
                m_out = 1'b0; m_ptr = (m_owner + 1) % N;
            end else if (m_age == T - 1) begin
                exp_rsp_vd = N'(1) << m_owner;
                exp_hit = 1'b0; exp_tout = 1'b1; exp_tab = '0; exp_addr = '0; exp_data = '0;
                m_out = 1'b0; m_ptr = (m_owner + 1) % N;
            end else begin
                m_age++;
            end
        end
    end

    always @(negedge clk_i) begin
        chk("gnt",    64'(gnt_o),       64'(exp_gnt));
        chk("search", 64'(search_o),    64'(exp_search));
        chk("key",    64'(key_o),       64'(exp_key));
        chk("rsp_vd", 64'(rsp_vd_o),    64'(exp_rsp_vd));
        chk("hit",    64'(rsp_hit_o),   64'(exp_hit));
        chk("tout",   64'(rsp_tout_o),  64'(exp_tout));
        chk("tab",    64'(rsp_tab_o),   64'(exp_tab));
        chk("addr",   64'(rsp_addr_o),  64'(exp_addr));
        chk("data",   64'(rsp_data_o),  64'(exp_data));
        chk("stray",  64'(err_stray_o), 64'(exp_stray));
        chk("onehot", 64'($onehot0(gnt_o) && $onehot0(rsp_vd_o)), 64'(1));
    end

    // ---------------- engine responder ----------------
    int            eng_delay = 0;
    bit            eng_rand  = 1'b0;
    bit            eng_fixed = 1'b0;
    bit            inj_req   = 1'b0;
    logic          fx_hit  = 1'b0;
    logic [3:0]    fx_tab  = '0;
    logic [AW-1:0] fx_addr = '0;
    logic [DW-1:0] fx_data = '0;

    initial begin
        int cd;
        int d;
        bit fire;
        cd = 0;
        forever begin
            @(posedge clk_i);
            #1;
            fire = 1'b0;
            if (!rstn_i) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) fire = 1'b1;
                end
                if (search_o) begin
                    if (eng_rand) begin
                        case ($urandom % 16)
                            0:       d = 0;
                            1:       d = 63;
                            2:       d = 64;
                            3:       d = 70;
                            default: d = int'($urandom_range(1, 12));
                        endcase
                    end else begin
                        d = eng_delay;
                    end
                    cd = d;
                end
            end
            if (inj_req) begin
                fire    = 1'b1;
                inj_req = 1'b0;
            end
            hit_vd_i = fire;
            if (fire && eng_fixed) begin
                hit_i = fx_hit; hit_tab_i = fx_tab; hit_addr_i = fx_addr; hit_data_i = fx_data;
            end else begin
                hit_i = 1'($urandom); hit_tab_i = 4'($urandom);
                hit_addr_i = AW'($urandom); hit_data_i = DW'($urandom);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_key(input int k, input logic [RW-1:0] v);
        req_key_i[k*RW +: RW] = v;
    endtask

    task automatic wait_sig(input string name, input int which, input int maxc, output int at);
        bit ok;
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk_i);
            if ((which == 0 && search_o) || (which == 1 && rsp_vd_o != '0) ||
                (which == 2 && err_stray_o)) begin
                ok = 1'b1;
                at = cyc;
            end
        end
        chk(name, 64'(ok), 64'(1));
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (((int'(v) >> i) & 1) != 0) return i;
        return -1;
    endfunction

    initial begin
        int s, r, b;
        int got [5];
        int exp_order [5];
        logic [N-1:0] nr;
        logic [1:0] kk;
        exp_order = '{0, 1, 2, 3, 0};

        #2 rstn_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        @(negedge clk_i);
        chk("rst_gnt", 64'(gnt_o), 64'(0));
        chk("rst_search", 64'(search_o), 64'(0));
        chk("rst_rsp_vd", 64'(rsp_vd_o), 64'(0));
        chk("rst_key", 64'(key_o), 64'(0));
        chk("rst_stray", 64'(err_stray_o), 64'(0));

        // fairness: all four held, order from pointer 0
        eng_delay = 3; eng_fixed = 1'b0;
        for (int k = 0; k < N; k++) set_key(k, RW'($urandom));
        @(posedge clk_i); #1 req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_sig("fair_search", 0, 20, s);
            got[i] = oh_idx(gnt_o);
        end
        @(posedge clk_i); #1 req_i = '0;
        wait_sig("fair_rsp", 1, 20, r);
        for (int i = 0; i < 5; i++) chk("fair_order", 64'(got[i]), 64'(exp_order[i]));

        // single request with known payload
        set_key(1, 24'hABCDEF);
        eng_delay = 5; eng_fixed = 1'b1;
        fx_hit = 1'b1; fx_tab = 4'd2; fx_addr = 8'h1F; fx_data = 32'hDEADBEEF;
        @(posedge clk_i); #1 req_i = 4'b0010;
        wait_sig("single_search", 0, 10, s);
        chk("single_gnt", 64'(gnt_o), 64'(4'b0010));
        chk("single_key", 64'(key_o), 64'(24'hABCDEF));
        @(posedge clk_i); #1 req_i = '0;
        wait_sig("single_rsp", 1, 20, r);
        chk("single_rsp_vd", 64'(rsp_vd_o), 64'(4'b0010));
        chk("single_hit", 64'(rsp_hit_o), 64'(1));
        chk("single_tab", 64'(rsp_tab_o), 64'(2));
        chk("single_addr", 64'(rsp_addr_o), 64'(8'h1F));
        chk("single_data", 64'(rsp_data_o), 64'(32'hDEADBEEF));
        chk("single_tout", 64'(rsp_tout_o), 64'(0));
        chk("single_latency", 64'(r - s), 64'(6));

        // busy hold-off
        eng_delay = 4; eng_fixed = 1'b0;
        @(posedge clk_i); #1 busy_i = 4'b0100; req_i = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk("busy_nosearch", 64'(search_o), 64'(0));
        end
        @(posedge clk_i); #1 busy_i = '0; b = cyc;
        wait_sig("busy_search", 0, 10, s);
        chk("busy_gnt", 64'(gnt_o), 64'(4'b0001));
        chk("busy_gnt_delay", 64'(s - b), 64'(1));
        @(posedge clk_i); #1 req_i = '0;
        wait_sig("busy_rsp", 1, 20, r);

        // timeout, then a late result that must be flagged stray
        eng_delay = 0;
        @(posedge clk_i); #1 req_i = 4'b0100;
        wait_sig("tout_search", 0, 10, s);
        @(posedge clk_i); #1 req_i = '0;
        wait_sig("tout_rsp", 1, 80, r);
        chk("tout_latency", 64'(r - s), 64'(64));
        chk("tout_rsp_vd", 64'(rsp_vd_o), 64'(4'b0100));
        chk("tout_flag", 64'(rsp_tout_o), 64'(1));
        chk("tout_hit", 64'(rsp_hit_o), 64'(0));
        chk("tout_tab", 64'(rsp_tab_o), 64'(0));
        chk("tout_addr", 64'(rsp_addr_o), 64'(0));
        chk("tout_data", 64'(rsp_data_o), 64'(0));
        repeat (s + 69 - r) @(negedge clk_i);
        inj_req = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("late_stray", 64'(err_stray_o), 64'(1));
        chk("late_no_rsp", 64'(rsp_vd_o), 64'(0));

        // hit arrives in the same cycle the counter reaches its limit
        eng_delay = 63; eng_fixed = 1'b1;
        fx_hit = 1'b1; fx_tab = 4'd5; fx_addr = 8'h3C; fx_data = 32'h12345678;
        @(posedge clk_i); #1 req_i = 4'b1000;
        wait_sig("tie_search", 0, 10, s);
        @(posedge clk_i); #1 req_i = '0;
        wait_sig("tie_rsp", 1, 80, r);
        chk("tie_latency", 64'(r - s), 64'(64));
        chk("tie_rsp_vd", 64'(rsp_vd_o), 64'(4'b1000));
        chk("tie_tout", 64'(rsp_tout_o), 64'(0));
        chk("tie_hit", 64'(rsp_hit_o), 64'(1));
        chk("tie_tab", 64'(rsp_tab_o), 64'(5));
        chk("tie_addr", 64'(rsp_addr_o), 64'(8'h3C));
        chk("tie_data", 64'(rsp_data_o), 64'(32'h12345678));

        // reset in the middle of an outstanding search
        eng_delay = 0; eng_fixed = 1'b0;
        @(posedge clk_i); #1 req_i = 4'b0010;
        wait_sig("rstw_search", 0, 10, s);
        chk("rstw_gnt", 64'(gnt_o), 64'(4'b0010));
        @(posedge clk_i); #1 req_i = '0;
        repeat (4) @(posedge clk_i);
        #1 rstn_i = 1'b0;
        @(negedge clk_i);
        chk("rstw_gnt0", 64'(gnt_o), 64'(0));
        chk("rstw_rsp0", 64'(rsp_vd_o), 64'(0));
        chk("rstw_key0", 64'(key_o), 64'(0));
        chk("rstw_tout0", 64'(rsp_tout_o), 64'(0));
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rstn_i = 1'b1;
        @(negedge clk_i);
        inj_req = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rstw_stray", 64'(err_stray_o), 64'(1));
        chk("rstw_no_rsp", 64'(rsp_vd_o), 64'(0));
        @(posedge clk_i); #1 req_i = 4'b1000;
        wait_sig("rstw_post_search", 0, 10, s);
        chk("rstw_post_gnt", 64'(gnt_o), 64'(4'b1000));
        @(posedge clk_i); #1 req_i = '0;

        // randomized traffic
        eng_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_i);
            #1;
            if (i == 1500) rstn_i = 1'b0;
            if (i == 1502) rstn_i = 1'b1;
            nr = req_i;
            for (int k = 0; k < N; k++) begin
                kk = 2'(k);
                if (nr[kk]) begin
                    if (gnt_o[kk] || ($urandom % 80) == 0) nr[kk] = 1'b0;
                end else if (($urandom % 6) == 0) begin
                    nr[kk] = 1'b1;
                    set_key(k, RW'($urandom));
                end
            end
            req_i = nr;
            if (busy_i == '0) begin
                if (($urandom % 20) == 0) busy_i = NT'($urandom_range(1, 15));
            end else if (($urandom % 4) == 0) begin
                busy_i = '0;
            end
            if (($urandom % 60) == 0) inj_req = 1'b1;
        end
        req_i = '0;
        busy_i = '0;
        repeat (150) @(posedge clk_i);
        @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/search_arb.md
Name: search_arb

Overview:
- Round-robin arbiter and sequencer that shares one rule-search engine (multi-table block-RAM search) between C_NUM_REQ requesters.
- Accepts one search at a time, drives the engine's search strobe and key, and waits for hit_vd_i or a timeout.
- Returns the result only to the requester that owns the search.
- Holds off new searches while any table is busy loading rules.

Parameters:
C_NUM_REQ, 4, number of requesters (2..8)
C_NUM_TABLE, 4, number of block RAMs in the engine (1,2,4,8,16)
C_RULE_WIDTH, 24, key/rule bit width
C_MEM_DATA_WIDTH, 56, RAM word width; result data width = C_MEM_DATA_WIDTH-C_RULE_WIDTH
C_MEM_ADDR_WIDTH, 8, RAM address width
C_TIMEOUT, 64, cycles to wait for hit_vd_i before aborting (>=4)

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
req_i  in  C_NUM_REQ  per-requester search request, held until gnt_o
req_key_i  in  C_NUM_REQ*C_RULE_WIDTH  packed keys, requester k at bits [k*C_RULE_WIDTH +: C_RULE_WIDTH]
gnt_o  out  C_NUM_REQ  one-hot, one-cycle grant pulse
rsp_vd_o  out  C_NUM_REQ  one-hot, one-cycle response-valid pulse to the owner
rsp_hit_o  out  1  search successful
rsp_tout_o  out  1  search aborted by timeout
rsp_tab_o  out  4  table of the hit
rsp_addr_o  out  C_MEM_ADDR_WIDTH  address of the hit
rsp_data_o  out  C_MEM_DATA_WIDTH-C_RULE_WIDTH  data of the hit
search_o  out  1  search strobe to the engine
key_o  out  C_RULE_WIDTH  key to the engine
busy_i  in  C_NUM_TABLE  per-table busy (rule load in progress)
hit_vd_i  in  1  engine result strobe
hit_i  in  1  engine hit flag
hit_tab_i  in  4  engine hit table
hit_addr_i  in  C_MEM_ADDR_WIDTH  engine hit address
hit_data_i  in  C_MEM_DATA_WIDTH-C_RULE_WIDTH  engine hit data
err_stray_o  out  1  one-cycle pulse: hit_vd_i arrived with no search outstanding

Behaviour:
- Reset: rstn_i is asynchronous and active-low; all flops reset asynchronously.
  - All outputs reset to 0.
  - State = IDLE, RR pointer = 0, timeout counter = 0.
- FSM has two states, IDLE and WAIT. All outputs are registered.
- IDLE, issuing a search:
  - A requester is eligible when req_i!=0 and busy_i==0 in cycle N.
  - Winner = first set req_i bit at or after the pointer, wrapping modulo C_NUM_REQ.
  - At N+1: gnt_o[winner]=1, search_o=1, key_o = winner's key sampled at N.
  - The owner is latched and the FSM moves to WAIT.
  - gnt_o and search_o are single-cycle pulses.
  - key_o holds its value until the next grant.
- busy_i!=0 in IDLE: no grant is issued; requests wait.
- WAIT, counter behaviour:
  - The counter increments every cycle from 0 starting at the search_o cycle.
  - New requests are not granted.
  - busy_i is ignored.
- WAIT, hit_vd_i=1 in cycle M:
  - At M+1: rsp_vd_o[owner]=1.
  - rsp_hit_o/tab/addr/data = values of hit_i/hit_tab_i/hit_addr_i/hit_data_i registered at M.
  - rsp_tout_o=0.
  - FSM returns to IDLE, pointer = (owner+1) mod C_NUM_REQ.
- WAIT, counter reaches C_TIMEOUT-1 with no hit_vd_i:
  - Next cycle: rsp_vd_o[owner]=1, rsp_tout_o=1, rsp_hit_o=0, tab/addr/data=0.
  - FSM returns to IDLE and the pointer advances as for a normal response.
- Simultaneous hit_vd_i and timeout in the same cycle: the hit wins and rsp_tout_o=0.
- rsp_* payload fields hold their values between rsp_vd_o pulses.
- Back-to-back searches: the earliest next search_o is 2 cycles after rsp_vd_o (IDLE sample cycle, then issue).
- hit_vd_i in IDLE, including a late result after a timeout: ignored for rsp_*; err_stray_o pulses the next cycle.
- A requester that drops req_i before gnt_o is not granted if it was not set in the sample cycle.
- Reset asserted during WAIT: the outstanding search is dropped and no rsp_vd_o is produced.
  - A hit_vd_i arriving after reset release gives err_stray_o.
- Exactly one bit of gnt_o and rsp_vd_o may be set at a time (assertion in bench).

Test Plan:
- Single request: req_i=4'b0010, key1=24'hABCDEF, engine returns hit_i=1, tab=2, addr=8'h1F, data=32'hDEADBEEF 5 cycles after search_o -> gnt_o=4'b0010, key_o=24'hABCDEF, one search_o pulse, rsp_vd_o=4'b0010 one cycle after hit_vd_i with matching payload, rsp_tout_o=0.
- Fairness: req_i=4'b1111 held, engine answers each search after 3 cycles -> grant order 0,1,2,3,0; never two searches outstanding.
- Busy hold-off: busy_i=4'b0100 for 10 cycles with req_i=4'b0001 -> no search_o until busy_i==0, then gnt_o=4'b0001 one cycle later.
- Timeout: C_TIMEOUT=64, no hit_vd_i -> rsp_vd_o for the owner exactly 64 cycles after search_o with rsp_tout_o=1 and rsp_hit_o=0; a hit_vd_i at cycle 70 -> err_stray_o pulse and no rsp_vd_o.
- Tie: hit_vd_i in the same cycle the counter reaches 63 -> normal hit response, rsp_tout_o=0.
- Reset mid-WAIT: rstn_i low 2 cycles during WAIT -> all outputs 0, no response; post-reset req_i=4'b1000 -> granted (pointer 0 scan reaches bit 3).
